// File: rtl/pmod_arbiter_if.sv
// Wishbone slave bus between the management SoC and the PMOD-A arbiter.
interface pmod_arbiter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/pmod_arbiter.sv
// Shares the PMOD-A pads between the J1 core and a Wishbone GPIO bank, with a
// tri-stated guard interval on every ownership handover.
module pmod_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned WIDTH        = 8
) (
  input  logic               boardClk,
  input  logic               reset,
  pmod_arbiter_if.slave      wb,
  input  logic [WIDTH-1:0]   j1_write,
  input  logic [WIDTH-1:0]   j1_writeEnable,
  output logic [WIDTH-1:0]   j1_read,
  input  logic [WIDTH-1:0]   pad_in,
  output logic [WIDTH-1:0]   pad_out,
  output logic [WIDTH-1:0]   pad_oeb,
  output logic               owner,
  output logic               busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_OUT  = 2'd1;
  localparam logic [1:0] ADR_OEB  = 2'd2;
  localparam logic [1:0] ADR_IN   = 2'd3;

  typedef enum logic [1:0] {ST_J1, ST_GUARD, ST_WB} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   oeb_q, oeb_d;
  logic [WIDTH-1:0]   sync1_q, sync2_q;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  dat_q, dat_d;

  logic               bus_req_c;
  logic               bus_wr_c;
  logic [DATA_W-1:0]  rdata_c;
  logic               unused_bus_bits;

  assign unused_bus_bits = ^{wb.wbs_adr_i, wb.wbs_sel_i, wb.wbs_dat_i};

  // Register bank and single-cycle-ack Wishbone slave.
  always_comb begin
    bus_req_c = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
    bus_wr_c  = bus_req_c & wb.wbs_we_i & wb.wbs_sel_i[0];
    rdata_c   = '0;
    req_d     = req_q;
    out_d     = out_q;
    oeb_d     = oeb_q;
    case (wb.wbs_adr_i[3:2])
      ADR_CTRL: rdata_c = DATA_W'({owner_q, busy_q, req_q});
      ADR_OUT:  rdata_c = DATA_W'(out_q);
      ADR_OEB:  rdata_c = DATA_W'(oeb_q);
      ADR_IN:   rdata_c = DATA_W'(sync2_q);
      default:  rdata_c = '0;
    endcase
    if (bus_wr_c) begin
      case (wb.wbs_adr_i[3:2])
        ADR_CTRL: req_d = wb.wbs_dat_i[0];
        ADR_OUT:  out_d = wb.wbs_dat_i[WIDTH-1:0];
        ADR_OEB:  oeb_d = wb.wbs_dat_i[WIDTH-1:0];
        default:  ;
      endcase
    end
    ack_d = bus_req_c;
    dat_d = (bus_req_c && !wb.wbs_we_i) ? rdata_c : dat_q;
  end

  // Ownership FSM; reacts to the request bit as it is being written so the
  // guard starts on the cycle right after the CTRL write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      ST_J1: begin
        if (req_d) begin
          state_d = ST_GUARD;
          cnt_d   = CNT_W'(GUARD_CYCLES - 1);
        end
      end
      ST_WB: begin
        if (!req_d) begin
          state_d = ST_GUARD;
          cnt_d   = CNT_W'(GUARD_CYCLES - 1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = req_d ? ST_WB : ST_J1;
          owner_d = req_d;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_J1;
    endcase
    busy_d = (state_d == ST_GUARD);
  end

  always_ff @(posedge boardClk) begin
    if (!reset) begin
      state_q <= ST_J1;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      out_q   <= '0;
      oeb_q   <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  // Pad mux: nobody drives while a handover is in progress.
  always_comb begin
    pad_out = '0;
    pad_oeb = '1;
    case (state_q)
      ST_J1: begin
        pad_out = j1_write;
        pad_oeb = j1_writeEnable;
      end
      ST_WB: begin
        pad_out = out_q;
        pad_oeb = oeb_q;
      end
      default: ;
    endcase
  end

  assign j1_read      = pad_in;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: doc/pmod_arbiter.md
Name: pmod_arbiter

Overview:
- Shares the 8 PMOD-A pads (io 30..37) between the J1 core's pmodA port and a Wishbone-controlled GPIO register bank driven by the management SoC.
- Owner handover passes through a guard state in which all 8 pads are tri-stated for a fixed number of cycles, so the two drivers never overlap.
- Sits in user_project_wrapper between the J1 core and the io_in/io_out/io_oeb slices.

Parameters:
- GUARD_CYCLES, 4, cycles pads stay tri-stated during a handover (1..15).
- WIDTH, 8, number of shared pads.

Ports:
- boardClk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; only bit 0 is used.
- wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- j1_write  in  WIDTH  core output data.
- j1_writeEnable  in  WIDTH  core output enables, active-low (oeb sense).
- j1_read  out  WIDTH  pad input data to the core.
- pad_in  in  WIDTH  from io_in.
- pad_out  out  WIDTH  to io_out.
- pad_oeb  out  WIDTH  to io_oeb, 1 = tri-state.
- owner  out  1  0 = J1, 1 = Wishbone; valid only when busy = 0.
- busy  out  1  handover in progress.

Behaviour:
- Reset state (reset = 0 at a rising edge):
  - state = J1.
  - Registers: CTRL.req = 0, OUT = 0x00, OEB = 0xFF, IN sync flops = 0.
  - Outputs: wbs_ack_o = 0, wbs_dat_o = 0, owner = 0, busy = 0.
  - Reset applied mid-handover or mid-bus-cycle aborts it immediately; no ack is issued.
- Register map (word offsets):
  - 0x0 CTRL: bit0 req (RW); bit1 busy (RO); bit2 owner (RO).
  - 0x4 OUT [7:0] (RW).
  - 0x8 OEB [7:0] (RW).
  - 0xC IN [7:0] (RO, synchronised pads).
  - Unused read bits return 0.
  - Writes occur only when wbs_sel_i[0] = 1; writes to RO bits are ignored.
- Bus handshake:
  - A request is cyc & stb & !ack.
  - wbs_ack_o pulses high for exactly 1 cycle, on the cycle after the request.
  - Write data is taken on the request cycle. Read data is registered and valid with ack.
  - If stb is held, requests are acked on alternate cycles; no wait states, no error responses.
- IN register: pad_in passes through a 2-flop synchroniser; IN reflects pad_in with 2 cycles of latency.
- j1_read = pad_in, combinational and ungated in every state.
- FSM states: J1, GUARD, WB.
  - J1 -> GUARD when req = 1. WB -> GUARD when req = 0.
  - On entry to GUARD, guard counter = GUARD_CYCLES - 1. It decrements each cycle in GUARD.
  - At count 0, the FSM goes to WB if req = 1, else J1. This holds even if req toggled during GUARD; the counter is not restarted.
  - busy = 1 exactly while in GUARD. owner is registered and updates on leaving GUARD.
- Pad mux (combinational from state):
  - J1: pad_out = j1_write, pad_oeb = j1_writeEnable.
  - WB: pad_out = OUT, pad_oeb = OEB.
  - GUARD: pad_out = 0, pad_oeb = all 1s.
- Handover latency: a write setting req on cycle T gives GUARD for cycles T+1 .. T+GUARD_CYCLES, and the new owner drives from T+GUARD_CYCLES+1.
- OUT and OEB stay writable in any state; their values take effect only in WB.

Test Plan:
- Reset, then read all 4 registers -> CTRL = 0x0, OUT = 0x00, OEB = 0x000000FF, IN = synced pads. pad_oeb follows j1_writeEnable; j1_write = 0xA5 appears on pad_out.
- Write OUT = 0x3C, OEB = 0x0F, then CTRL = 0x1 at cycle T -> pad_oeb = 0xFF and busy = 1 for cycles T+1..T+4. At T+5: pad_out = 0x3C, pad_oeb = 0x0F, owner = 1, CTRL reads 0x5.
- In GUARD, write CTRL = 0x0 at cycle 2 of the guard -> guard still ends after 4 cycles, FSM returns to J1 with owner = 0, and WB never drives the pads.
- Drive pad_in = 0x81 -> IN reads 0x81 from 2 cycles later; j1_read = 0x81 immediately in all states.
- Write with wbs_sel_i = 0x0 to OUT -> OUT unchanged. With stb held for 6 cycles -> exactly 3 single-cycle acks.
- Assert reset during GUARD and during a pending ack -> next cycle: state J1, ack = 0, pad_oeb = j1_writeEnable, registers at reset values.
